// File: rtl/top_level_pkg.sv
// Shared types, constants and the Hamming(16,11) SECDED encoder
// used by the message-encoding engine.
package top_level_pkg;

    typedef enum logic [2:0] {
        RD_LO = 3'd0,
        RD_HI = 3'd1,
        ENC   = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam int          NUM_MSG  = 15;
    localparam logic [7:0]  IN_BASE  = 8'd0;
    localparam logic [7:0]  OUT_BASE = 8'd30;
    localparam logic [3:0]  LAST_IDX = 4'(NUM_MSG - 1);

    // Parity bits sit at code positions 1,2,4,8; bit 0 is overall parity.
    function automatic logic [15:0] hamming_enc(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = ^{d[11:8], d[4:2]};
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = ^{d, p8, p4, p2, p1};
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

endpackage

// File: rtl/data_mem.sv
// 256x8 data memory: combinational read, single synchronous write port.
// Contents survive reset so the bench can preload messages.
module data_mem (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] core [0:255];

    assign rdata = core[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            core[addr] <= wdata;
        end
    end

endmodule

// File: rtl/reg_file.sv
// 8x8 register file with one write port carrying per-register enables;
// all registers are visible on the read side every cycle.
module reg_file (
    input  logic            clk,
    input  logic [7:0]      we,
    input  logic [7:0][7:0] wd,
    output logic [7:0][7:0] rd
);

    logic [7:0] core [0:7];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (we[k]) begin
                core[k] <= wd[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            rd[k] = core[k];
        end
    end

endmodule

// File: rtl/top_level.sv
// Encodes 15 11-bit messages from data memory into 16-bit SECDED
// words, one FSM state per cycle, five cycles per message.
import top_level_pkg::*;

module top_level (
    input  logic clk,
    input  logic reset,
    output logic done
);

    state_t          state;
    logic [15:0]     prog_ctr;

    logic [7:0]      rf_we;
    logic [7:0][7:0] rf_wd;
    logic [7:0][7:0] rf_rd;

    logic            dm_we;
    logic [7:0]      dm_addr;
    logic [7:0]      dm_wdata;
    logic [7:0]      dm_rdata;

    logic [3:0]      idx;
    logic [7:0]      off;
    logic [15:0]     word;

    data_mem dm1 (
        .clk   (clk),
        .we    (dm_we),
        .addr  (dm_addr),
        .wdata (dm_wdata),
        .rdata (dm_rdata)
    );

    reg_file rf1 (
        .clk (clk),
        .we  (rf_we),
        .wd  (rf_wd),
        .rd  (rf_rd)
    );

    // r4 carries the message index; each message occupies two bytes.
    assign idx  = rf_rd[4][3:0];
    assign off  = {3'b000, idx, 1'b0};
    assign word = hamming_enc({rf_rd[1][2:0], rf_rd[0]});

    always_comb begin
        dm_addr = IN_BASE + off;
        unique case (state)
            RD_HI:   dm_addr = IN_BASE + off + 8'd1;
            WR_LO:   dm_addr = OUT_BASE + off;
            WR_HI:   dm_addr = OUT_BASE + off + 8'd1;
            default: dm_addr = IN_BASE + off;
        endcase
    end

    always_comb begin
        rf_we    = '0;
        rf_wd    = '0;
        dm_we    = 1'b0;
        dm_wdata = '0;
        if (reset) begin
            rf_we = '1;
        end else begin
            unique case (state)
                RD_LO: begin
                    rf_we[0] = 1'b1;
                    rf_wd[0] = dm_rdata;
                    rf_we[5] = 1'b1;
                    rf_wd[5] = dm_addr;
                end
                RD_HI: begin
                    rf_we[1] = 1'b1;
                    rf_wd[1] = dm_rdata;
                    rf_we[5] = 1'b1;
                    rf_wd[5] = dm_addr;
                end
                ENC: begin
                    rf_we[2] = 1'b1;
                    rf_wd[2] = word[7:0];
                    rf_we[3] = 1'b1;
                    rf_wd[3] = word[15:8];
                end
                WR_LO: begin
                    dm_we    = 1'b1;
                    dm_wdata = rf_rd[2];
                    rf_we[7] = 1'b1;
                    rf_wd[7] = rf_rd[2];
                    rf_we[6] = 1'b1;
                    rf_wd[6] = dm_addr;
                end
                WR_HI: begin
                    dm_we    = 1'b1;
                    dm_wdata = rf_rd[3];
                    rf_we[7] = 1'b1;
                    rf_wd[7] = rf_rd[3];
                    rf_we[6] = 1'b1;
                    rf_wd[6] = dm_addr;
                    rf_we[4] = 1'b1;
                    rf_wd[4] = {4'd0, idx + 4'd1};
                end
                default: begin
                    dm_we = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RD_LO;
            done     <= 1'b0;
            prog_ctr <= '0;
        end else begin
            if (state != FIN) begin
                prog_ctr <= prog_ctr + 16'd1;
            end
            unique case (state)
                RD_LO: state <= RD_HI;
                RD_HI: state <= ENC;
                ENC:   state <= WR_LO;
                WR_LO: state <= WR_HI;
                WR_HI: begin
                    if (idx == LAST_IDX) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state <= RD_LO;
                    end
                end
                FIN:     done  <= 1'b1;
                default: state <= RD_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_top_level.sv
// Directed bench for the SECDED encoding engine: preloads memory,
// runs the encoder and compares outputs against hand/model values.
module tb_top_level;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic done;

    int tests = 0;
    int fails = 0;

    logic [7:0]  img  [0:255];
    logic [7:0]  lo   [0:14];
    logic [7:0]  hi   [0:14];
    logic [15:0] expw [0:14];

    top_level dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Classic positional Hamming: data fills non-power-of-two slots.
    function automatic logic [15:0] ref_enc(input logic [10:0] d);
        logic [15:0] cw;
        logic        p;
        int          j;
        cw = '0;
        j  = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int pos = 1; pos < 16; pos++) begin
                if (((pos >> k) & 1) == 1) p = p ^ cw[pos];
            end
            cw[1 << k] = p;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    task automatic load();
        for (int k = 0; k < 256; k++) img[k] = 8'hC3 ^ 8'(k);
        for (int k = 30; k < 60; k++) img[k] = 8'h5A;
        for (int i = 0; i < 15; i++) begin
            img[2*i]   = lo[i];
            img[2*i+1] = hi[i];
        end
        for (int k = 0; k < 256; k++) dut.dm1.core[k] = img[k];
    endtask

    task automatic start();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pc", {16'd0, dut.prog_ctr}, 32'd0);
        check("rst_r4", {24'd0, dut.rf1.core[4]}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int e = 1; e <= 90; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = e;
                break;
            end
        end
    endtask

    task automatic verify(input string tag);
        int bad;
        for (int i = 0; i < 15; i++) begin
            check(tag, {16'd0, dut.dm1.core[31+2*i], dut.dm1.core[30+2*i]},
                  {16'd0, expw[i]});
        end
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if ((k < 30 || k >= 60) && dut.dm1.core[k] !== img[k]) bad++;
        end
        check({tag, "_keep"}, bad, 0);
    endtask

    task automatic finish_checks(input string tag, input int n);
        check({tag, "_edge"}, n, 75);
        check({tag, "_pc"}, {16'd0, dut.prog_ctr}, 32'd75);
        check({tag, "_r4"}, {24'd0, dut.rf1.core[4]}, 32'd15);
        check({tag, "_r7"}, {24'd0, dut.rf1.core[7]}, {24'd0, expw[14][15:8]});
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_hold"}, {31'd0, done}, 32'd1);
        check({tag, "_frz"}, {16'd0, dut.prog_ctr}, 32'd75);
    endtask

    initial begin
        int n;
        logic [10:0] d;

        // All-zero inputs encode to all-zero words.
        for (int i = 0; i < 15; i++) begin
            lo[i] = 8'h00; hi[i] = 8'h00; expw[i] = 16'h0000;
        end
        load();
        start();
        wait_done(n);
        finish_checks("zero", n);
        verify("zero");

        // Hand-computed vectors, including ignored high-byte bits.
        lo[0] = 8'hFF; hi[0] = 8'h07; expw[0] = 16'hFFFF;
        lo[1] = 8'h01; hi[1] = 8'h00; expw[1] = 16'h000F;
        lo[2] = 8'h00; hi[2] = 8'h04; expw[2] = 16'h8117;
        lo[3] = 8'h00; hi[3] = 8'hF8; expw[3] = 16'h0000;
        load();
        start();
        wait_done(n);
        finish_checks("dir", n);
        verify("dir");

        // Random messages against the positional reference model.
        for (int i = 0; i < 15; i++) begin
            d       = 11'($urandom_range(0, 2047));
            lo[i]   = d[7:0];
            hi[i]   = {5'($urandom), d[10:8]};
            expw[i] = ref_enc(d);
        end
        load();
        start();
        wait_done(n);
        finish_checks("rnd", n);
        verify("rnd");

        // Reset pulse at edge 40 aborts and restarts the run.
        load();
        start();
        repeat (39) @(posedge clk);
        #1;
        check("mid_pre", {31'd0, done}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_done", {31'd0, done}, 32'd0);
        check("mid_pc", {16'd0, dut.prog_ctr}, 32'd0);
        reset = 1'b0;
        wait_done(n);
        finish_checks("mid", n);
        verify("mid");

        // Reset from FIN drops done on the next edge.
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("fin_rst", {31'd0, done}, 32'd0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/top_level.md
TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 SHALL have no parameters; constants NUM_MSG=15, IN_BASE=0, OUT_BASE=30.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high; restarts the encode run.
REQ-004 done  output  1  high when all 15 encoded words are written; held until next reset.
REQ-005 SHALL contain instance dm1 with array core[0:255] of 8-bit bytes, writable hierarchically by a bench before reset.
REQ-006 SHALL contain instance rf1 with array core[0:7] of 8-bit registers, and an internal counter named prog_ctr.

Function
REQ-007 Message i (0..14): d[8:1] = dm1.core[2i], d[11:9] = dm1.core[2i+1][2:0]; bits [7:3] of the high byte ignored.
REQ-008 Parity: p8 = XOR d[11:5]; p4 = XOR d[11:8],d[4:2]; p2 = d11^d10^d7^d6^d4^d3^d1; p1 = d11^d9^d7^d5^d4^d2^d1; p0 = XOR of all d bits, p8, p4, p2, p1.
REQ-009 Encoded word W[15:0] = {d[11:5], p8, d[4:2], p4, d1, p2, p1, p0}.
REQ-010 SHALL write W[7:0] to dm1.core[30+2i] and W[15:8] to dm1.core[31+2i].
REQ-011 SHALL never write dm1 addresses 0..29 or 60..255.
REQ-012 dm1: combinational read, synchronous write, one write port, one write per cycle max.
REQ-013 FSM states RD_LO, RD_HI, ENC, WR_LO, WR_HI, FIN; one state per cycle.
REQ-014 RD_LO: r0 <= core[2i]; RD_HI: r1 <= core[2i+1]; ENC: r2 <= W[7:0], r3 <= W[15:8]; WR_LO: write r2, r7 <= r2; WR_HI: write r3, r7 <= r3, i <= i+1.
REQ-015 WR_HI: if i==14 go FIN, else RD_LO; FIN is absorbing until reset.
REQ-016 r4 holds i; r5 holds current read address; r6 holds current write address.
REQ-017 prog_ctr increments by 1 each cycle outside FIN; frozen in FIN.
REQ-018 Latency: 5 cycles per message; done registered high on the 75th rising edge after the first edge with reset low.
REQ-019 done SHALL be a registered output, high only in FIN.
REQ-020 Output region never overlaps input region, so rerunning is idempotent.

Reset
REQ-021 While reset is high at a clock edge: state <= RD_LO, i <= 0, prog_ctr <= 0, rf1.core[*] <= 0, done <= 0.
REQ-022 Reset SHALL NOT clear or modify dm1 contents.
REQ-023 Reset mid-run (any state, including FIN) SHALL abort and restart from message 0; done low from the next edge; partially written outputs are rewritten with identical values.

Structure
REQ-024 Package top_level_pkg SHALL hold the state enum, NUM_MSG, IN_BASE, OUT_BASE, and a pure function hamming_enc(11-bit d) returning 16-bit W.
REQ-025 Sub-modules: data_mem (instance dm1, 256x8) and reg_file (instance rf1, 8x8, one write port); the FSM and datapath stay in top_level.

Verification
REQ-026 All input bytes 0x00, pulse reset -> every output pair 0x00/0x00; done high at edge 75.
REQ-027 Message 0 bytes low=0xFF, high=0x07 -> core[30]=0xFF, core[31]=0xFF.
REQ-028 Message 0 bytes low=0x01, high=0x00 -> 0x0F/0x00; low=0x00, high=0x04 -> 0x17/0x81.
REQ-029 High byte 0xF8, low 0x00 -> output 0x00/0x00 (upper bits ignored); core[60..255] unchanged.
REQ-030 15 random 11-bit messages -> all 15 output pairs match hamming_enc; inputs 0..29 unchanged.
REQ-031 Assert reset at edge 40 for one cycle -> done low, run restarts, final outputs correct, done at edge 75 after release.
